// File: rtl/layer_mem_ctrl.sv
// layer_mem_ctrl: multi-layer pixel memory controller for the VGA path.
// Generates a pixel strobe every DIV clocks and registers one ROM address per layer
// (req_addr + layer base, wrapping) on each accepted request. The request sideband
// is delayed to match the ROM read latency, and the layers are then composited by
// priority, with layer LAYERS-1 winning.
// Build option: define COLOR_KEY_EN to treat KEY_COLOR as transparent during compose.
module layer_mem_ctrl #(
  parameter int unsigned LAYERS  = 2,
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned PIX_W   = 12,
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned DIV     = 4,
  parameter logic [PIX_W-1:0] KEY_COLOR = 12'h0F0,
  parameter logic [PIX_W-1:0] BG_COLOR  = 12'h000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       pix_tick,
  input  logic                       req_valid,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [LAYERS-1:0]          layer_en,
  input  logic [LAYERS*ADDR_W-1:0]   layer_base,
  output logic [LAYERS*ADDR_W-1:0]   rom_addr,
  input  logic [LAYERS*PIX_W-1:0]    rom_data,
  output logic                       pix_valid,
  output logic [PIX_W-1:0]           pixel,
  output logic [$clog2(LAYERS+1)-1:0] pix_layer
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam int unsigned LW = $clog2(LAYERS + 1);
`ifdef COLOR_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     tick_q, tick_d;
  logic                     accept;
  logic [LAYERS*ADDR_W-1:0] addr_q, addr_d;
  logic [ROM_LAT:0]         vld_q;
  logic [LAYERS-1:0]        en_q [ROM_LAT+1];
  logic [PIX_W-1:0]         win_pix;
  logic [LW-1:0]            win_idx;
  logic                     pv_q;
  logic [PIX_W-1:0]         pixel_q, pixel_d;
  logic [LW-1:0]            layer_q, layer_d;

  // The tick is registered from the next count, so it stays low during reset
  // even with DIV=1 while still lining up with count==DIV-1 afterwards.
  always_comb begin
    cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_d == CNT_MAX);
  end

  // Tick counter and strobe register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign accept = req_valid & tick_q;

  // Next per-layer ROM address: offset by the layer base and wrapped to ADDR_W.
  always_comb begin
    addr_d = addr_q;
    if (accept) begin
      for (int unsigned i = 0; i < LAYERS; i++) begin
        addr_d[i*ADDR_W +: ADDR_W] = req_addr + layer_base[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Address stage: holds the value between accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  // Sideband shift pipeline: stage 0 is aligned with rom_addr, and stage ROM_LAT
  // is aligned with rom_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned k = 0; k <= ROM_LAT; k++) en_q[k] <= '0;
    end else begin
      vld_q[0] <= accept;
      if (accept) en_q[0] <= layer_en;
      for (int unsigned k = 1; k <= ROM_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        en_q[k]  <= en_q[k-1];
      end
    end
  end

  // Priority compose: an ascending scan leaves the highest qualifying layer.
  always_comb begin
    win_pix = BG_COLOR;
    win_idx = LW'(LAYERS);
    for (int unsigned i = 0; i < LAYERS; i++) begin
      if (en_q[ROM_LAT][i] && (!KEY_EN || (rom_data[i*PIX_W +: PIX_W] != KEY_COLOR))) begin
        win_pix = rom_data[i*PIX_W +: PIX_W];
        win_idx = LW'(i);
      end
    end
    pixel_d = pixel_q;
    layer_d = layer_q;
    if (vld_q[ROM_LAT]) begin
      pixel_d = win_pix;
      layer_d = win_idx;
    end
  end

  // Output stage: registered pixel and layer, held while no pixel is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q    <= 1'b0;
      pixel_q <= '0;
      layer_q <= '0;
    end else begin
      pv_q    <= vld_q[ROM_LAT];
      pixel_q <= pixel_d;
      layer_q <= layer_d;
    end
  end

  assign pix_tick  = tick_q;
  assign rom_addr  = addr_q;
  assign pix_valid = pv_q;
  assign pixel     = pixel_q;
  assign pix_layer = layer_q;

endmodule

// File: tb/tb_layer_mem_ctrl.sv
// Directed bench for layer_mem_ctrl: a DIV=4 instance and a DIV=1 instance, each
// paired with a one-cycle ROM model whose data is the low 12 bits of its address.
module tb_layer_mem_ctrl;

`ifdef COLOR_KEY_EN
  localparam bit KEYED = 1'b1;
`else
  localparam bit KEYED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_valid, pix_tick, pix_valid;
  logic [16:0] req_addr;
  logic [1:0]  layer_en, pix_layer;
  logic [33:0] layer_base, rom_addr;
  logic [23:0] rom_data;
  logic [11:0] pixel;

  logic        req1_valid, pix_tick1, pix_valid1;
  logic [16:0] req1_addr;
  logic [1:0]  layer_en1, pix_layer1;
  logic [33:0] layer_base1, rom_addr1;
  logic [23:0] rom_data1;
  logic [11:0] pixel1;

  int n_cmp = 0;
  int n_err = 0;
  logic [33:0] last_ra;

  always #5 clk = ~clk;

  layer_mem_ctrl #(.LAYERS(2), .ADDR_W(17), .PIX_W(12), .ROM_LAT(1), .DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .req_valid(req_valid),
    .req_addr(req_addr), .layer_en(layer_en), .layer_base(layer_base),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_valid(pix_valid),
    .pixel(pixel), .pix_layer(pix_layer));

  layer_mem_ctrl #(.LAYERS(2), .ADDR_W(17), .PIX_W(12), .ROM_LAT(1), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick1), .req_valid(req1_valid),
    .req_addr(req1_addr), .layer_en(layer_en1), .layer_base(layer_base1),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .pix_valid(pix_valid1),
    .pixel(pixel1), .pix_layer(pix_layer1));

  // ROM models: each layer returns the low 12 bits of its address after one clock.
  always @(posedge clk) begin
    rom_data  <= {rom_addr[28:17], rom_addr[11:0]};
    rom_data1 <= {rom_addr1[28:17], rom_addr1[11:0]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick(input string tag);
    int guard = 0;
    while (pix_tick !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check({tag, "_tick_timeout"}, 0, 1);
  endtask

  // One request at the next tick. The sideband is scrambled right after the accept,
  // and the result is then checked for latency, value, a one-cycle pulse and hold.
  task automatic send(input string tag, input logic [16:0] a, input logic [1:0] en,
                      input logic [16:0] b0, input logic [16:0] b1,
                      input logic [11:0] epix, input logic [1:0] elay);
    int lat = 0;
    wait_tick(tag);
    req_valid  = 1'b1;
    req_addr   = a;
    layer_en   = en;
    layer_base = {b1, b0};
    @(negedge clk);
    req_valid  = 1'b0;
    layer_en   = ~en;
    layer_base = 34'h2_AAAA_5555;
    req_addr   = ~a;
    last_ra    = rom_addr;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      if (pix_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, lat, 3);
    check({tag, "_pix"}, pixel, epix);
    check({tag, "_layer"}, pix_layer, elay);
    @(negedge clk);
    check({tag, "_pulse"}, pix_valid, 0);
    @(negedge clk);
    check({tag, "_hold"}, pixel, epix);
  endtask

  initial begin
    int p, cnt, rcv, first, last;
    logic [16:0] bb;
    req_valid = 0; req_addr = '0; layer_en = '0; layer_base = '0;
    req1_valid = 0; req1_addr = '0; layer_en1 = 2'b01; layer_base1 = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_tick", pix_tick, 0);
    check("rst_tick1", pix_tick1, 0);
    check("rst_romaddr", rom_addr, 0);
    check("rst_pv", pix_valid, 0);
    check("rst_pixel", pixel, 0);
    check("rst_layer", pix_layer, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Tick period and pulse width
    wait_tick("period");
    p = 0;
    do begin
      @(negedge clk);
      p++;
    end while (pix_tick !== 1'b1 && p < 20);
    check("tick_period", p, 4);
    @(negedge clk);
    check("tick_pulse", pix_tick, 0);

    // Priority and colour key: L1=0F0 (key), L0=F00
    bb = 17'h000F0 - 17'h00F00;
    send("t3a", 17'h00F00, 2'b11, 17'h0, bb, KEYED ? 12'hF00 : 12'h0F0, KEYED ? 2'd0 : 2'd1);
    bb = 17'h0000F - 17'h00F00;
    send("t3b", 17'h00F00, 2'b11, 17'h0, bb, 12'h00F, 2'd1);
    // Background cases
    send("t4_en0", 17'h00123, 2'b00, 17'h0, 17'h0, 12'h000, 2'd2);
    send("t4_key", 17'h000F0, 2'b11, 17'h0, 17'h0, KEYED ? 12'h000 : 12'h0F0, KEYED ? 2'd2 : 2'd1);
    send("t4_l1key", 17'h000F0, 2'b10, 17'h0, 17'h0, KEYED ? 12'h000 : 12'h0F0, KEYED ? 2'd2 : 2'd1);
    // Address wrap and offset
    send("t5", 17'h1FFFF, 2'b11, 17'h0, 17'h2, 12'h001, 2'd1);
    check("t5_ra1", last_ra[33:17], 17'h00001);
    check("t5_ra0", last_ra[16:0], 17'h1FFFF);
    check("t5_ra_hold", rom_addr, {17'h00001, 17'h1FFFF});
    send("t5_en01", 17'h1FFFF, 2'b01, 17'h0, 17'h2, 12'hFFF, 2'd0);

    // req_valid held across three ticks: exactly three accepts
    wait_tick("held");
    req_valid = 1'b1; req_addr = 17'h00555; layer_en = 2'b01; layer_base = '0;
    cnt = 0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (pix_valid === 1'b1) cnt++;
      if (i == 12) req_valid = 1'b0;
    end
    check("held_accepts", cnt, 3);
    check("held_pix", pixel, 12'h555);

    // DIV=1 throughput: 100 back-to-back requests
    check("div1_tick", pix_tick1, 1);
    req1_valid = 1'b1; req1_addr = 17'd0;
    rcv = 0; first = -1; last = -1;
    for (int n = 1; n <= 120; n++) begin
      @(negedge clk);
      if (pix_valid1 === 1'b1) begin
        check("t6_pix", pixel1, rcv);
        if (first < 0) first = n;
        last = n;
        rcv++;
      end
      if (n < 100) req1_addr = 17'(n);
      else         req1_valid = 1'b0;
    end
    check("t6_count", rcv, 100);
    check("t6_span", last - first + 1, 100);
    check("t6_first_lat", first, 3);

    // Reset mid-stream with requests in flight on both instances
    wait_tick("midrst");
    req_valid = 1'b1; req_addr = 17'h00321; layer_en = 2'b01; layer_base = '0;
    req1_valid = 1'b1; req1_addr = 17'h00777;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_tick", pix_tick, 0);
    check("mr_tick1", pix_tick1, 0);
    check("mr_romaddr", rom_addr, 0);
    check("mr_romaddr1", rom_addr1, 0);
    check("mr_pv", pix_valid, 0);
    check("mr_pv1", pix_valid1, 0);
    check("mr_pixel", pixel, 0);
    check("mr_pixel1", pixel1, 0);
    check("mr_layer", pix_layer, 0);
    req1_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pix_valid === 1'b1 || pix_valid1 === 1'b1) cnt++;
    end
    check("mr_no_valid", cnt, 0);
    send("post_rst", 17'h000AB, 2'b01, 17'h0, 17'h0, 12'h0AB, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
